fft_stage_pingpong_buffer: RTL and testbench
============================================

FFT_STAGE_PINGPONG_BUFFER -- requirements
Module: fft_stage_pingpong_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, signed two's-complement bits per real/imag sample.
REQ-002 SHALL have parameter NPTS, default 16, complex lanes per frame; legal values are powers of 2 from 4 to 64.
REQ-003 SHALL have localparam LOG2N = log2(NPTS), used for lane index width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port in_valid  input  1  frame present on in_re/in_im.
REQ-007 SHALL have port in_ready  output  1  buffer can accept a frame this cycle.
REQ-008 SHALL have port in_re  input  NPTS*WIDTH  real lanes; lane k at bits [k*WIDTH +: WIDTH].
REQ-009 SHALL have port in_im  input  NPTS*WIDTH  imag lanes, same packing.
REQ-010 SHALL have port bitrev_en  input  1  reorder lanes bit-reversed, sampled at accept.
REQ-011 SHALL have port scale_en  input  1  halve samples with rounding, sampled at accept.
REQ-012 SHALL have port out_valid  output  1  a stored frame is presented.
REQ-013 SHALL have port out_ready  input  1  downstream consumes the frame this cycle.
REQ-014 SHALL have port out_re  output  NPTS*WIDTH  real lanes of head frame.
REQ-015 SHALL have port out_im  output  NPTS*WIDTH  imag lanes of head frame.
REQ-016 SHALL have port level  output  2  frames stored, 0..2.

Function
REQ-017 SHALL hold two frame banks (ping/pong), a 1-bit write pointer wp, a 1-bit read pointer rp, and count 0..2; level = count.
REQ-018 SHALL drive in_ready = (count != 2), combinationally from registered count.
REQ-019 SHALL accept on in_valid && in_ready: write bank[wp], toggle wp, count+1 unless a pop occurs in the same cycle.
REQ-020 SHALL drive out_valid = (count != 0); out_re/out_im = bank[rp], purely from registers.
REQ-021 SHALL pop on out_valid && out_ready: toggle rp, count-1 unless an accept occurs in the same cycle.
REQ-022 SHALL, on simultaneous accept and pop (possible only at count 1), toggle both pointers and keep count at 1; the newly written frame is presented next cycle.
REQ-023 SHALL give a latency of exactly 1 cycle from accept edge to out_valid for a frame entering an empty buffer.
REQ-024 SHALL hold out_re/out_im/out_valid stable while out_valid && !out_ready.
REQ-025 SHALL ignore in_valid when in_ready = 0; nothing is written and no state changes from the input side.
REQ-026 SHALL store lane k at bank lane bitrev(k, LOG2N) when bitrev_en = 1 at accept, else at lane k.
REQ-027 SHALL, when scale_en = 1 at accept, store each re/im sample as (x + 1) >>> 1, computed in WIDTH+1 bits and truncated to WIDTH.
REQ-028 SHALL make the REQ-027 result never overflow, e.g. 32767 -> 16384, -32768 -> -16384, 3 -> 2, -3 -> -1.
REQ-029 SHALL apply scaling and reordering independently per frame; mode inputs are don't-care when no accept occurs.

Reset
REQ-030 SHALL, on rst_n low, asynchronously clear count, wp, rp and both banks to 0.
REQ-031 SHALL therefore give out_valid = 0, level = 0, out_re = out_im = 0 and in_ready = 1 during and after reset.
REQ-032 SHALL, on reset mid-operation, discard all stored frames with no partial output; the first accept after release goes to bank 0.

Verification
REQ-033 SHALL cover passthrough: NPTS=16, in_re lane k = k, in_im = 0, bitrev_en = 0, scale_en = 0, one accept -> next cycle out_valid = 1, out_re lane k = k, level = 1.
REQ-034 SHALL cover bit-reverse: same ramp with bitrev_en = 1 -> out_re lanes 0..3 = 0, 8, 4, 12 and lane 15 = 15.
REQ-035 SHALL cover backpressure: out_ready = 0, offer frames A, B, C on consecutive cycles -> A and B accepted, in_ready = 0 at C, level = 2, out shows A; out_ready = 1 for one cycle -> out shows B, level = 1, then C is accepted.
REQ-036 SHALL cover scaling: scale_en = 1, lanes {32767, -32768, 3, -3} -> {16384, -16384, 2, -1}.
REQ-037 SHALL cover simultaneous push/pop: level = 1 holding A, out_ready = 1 and accept B in the same cycle -> level stays 1, out shows B next cycle.
REQ-038 SHALL cover reset mid-operation: level = 2, pulse rst_n low between clock edges -> out_valid = 0, level = 0 and outputs 0 immediately; after release a new frame appears 1 cycle after accept.

Source files
------------

// File: rtl/fft_stage_pingpong_buffer.sv
// Two-frame ping/pong buffer between FFT stages.
// Each accepted frame can be halved with rounding and/or lane-reordered into
// bit-reversed order before being stored; the head frame is presented
// straight from the bank registers so the output path has no input logic.
module fft_stage_pingpong_buffer #(
  parameter int WIDTH = 16,
  parameter int NPTS  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NPTS*WIDTH-1:0]   in_re,
  input  logic [NPTS*WIDTH-1:0]   in_im,
  input  logic                    bitrev_en,
  input  logic                    scale_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NPTS*WIDTH-1:0]   out_re,
  output logic [NPTS*WIDTH-1:0]   out_im,
  output logic [1:0]              level
);

  localparam int LOG2N = $clog2(NPTS);
  localparam int FW    = NPTS * WIDTH;

  // Reverse the bit order of a lane index.
  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] k);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int b = 0; b < LOG2N; b++) begin
      r[b] = k[LOG2N-1-b];
    end
    return r;
  endfunction

  // Frame storage and control state.
  logic [FW-1:0] bank_re_reg [2];
  logic [FW-1:0] bank_im_reg [2];
  logic          wp_reg, wp_next;
  logic          rp_reg, rp_next;
  logic [1:0]    count_reg, count_next;

  logic          accept;
  logic          pop;

  // Datapath: optional rounding halve, then optional bit-reverse reorder.
  logic [FW-1:0] scaled_re;
  logic [FW-1:0] scaled_im;
  logic [FW-1:0] wr_re;
  logic [FW-1:0] wr_im;

  genvar gi;

  // (x + 1) >>> 1 evaluated one bit wider so +1 on the maximum value
  // cannot wrap; the shifted result always fits back in WIDTH bits.
  generate
    for (gi = 0; gi < NPTS; gi++) begin : g_scale
      logic signed [WIDTH:0] ext_re;
      logic signed [WIDTH:0] ext_im;
      assign ext_re = $signed({in_re[gi*WIDTH+WIDTH-1], in_re[gi*WIDTH +: WIDTH]})
                      + $signed((WIDTH+1)'(1));
      assign ext_im = $signed({in_im[gi*WIDTH+WIDTH-1], in_im[gi*WIDTH +: WIDTH]})
                      + $signed((WIDTH+1)'(1));
      assign scaled_re[gi*WIDTH +: WIDTH] = scale_en ? ext_re[WIDTH:1]
                                                     : in_re[gi*WIDTH +: WIDTH];
      assign scaled_im[gi*WIDTH +: WIDTH] = scale_en ? ext_im[WIDTH:1]
                                                     : in_im[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Bit reversal is its own inverse, so storing lane k at bitrev(k) is the
  // same as filling stored lane j from input lane bitrev(j).
  generate
    for (gi = 0; gi < NPTS; gi++) begin : g_reorder
      localparam int SRC = int'(bitrev(LOG2N'(gi)));
      assign wr_re[gi*WIDTH +: WIDTH] = bitrev_en ? scaled_re[SRC*WIDTH +: WIDTH]
                                                  : scaled_re[gi*WIDTH +: WIDTH];
      assign wr_im[gi*WIDTH +: WIDTH] = bitrev_en ? scaled_im[SRC*WIDTH +: WIDTH]
                                                  : scaled_im[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Handshake outputs come only from registered state.
  assign in_ready  = (count_reg != 2'd2);
  assign out_valid = (count_reg != 2'd0);
  assign level     = count_reg;
  assign out_re    = bank_re_reg[rp_reg];
  assign out_im    = bank_im_reg[rp_reg];

  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;

  // Next pointer/occupancy; a same-cycle accept and pop leaves count unchanged.
  always_comb begin
    wp_next    = wp_reg;
    rp_next    = rp_reg;
    count_next = count_reg;
    if (accept) begin
      wp_next = ~wp_reg;
    end
    if (pop) begin
      rp_next = ~rp_reg;
    end
    case ({accept, pop})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_reg    <= 1'b0;
      rp_reg    <= 1'b0;
      count_reg <= 2'd0;
    end else begin
      wp_reg    <= wp_next;
      rp_reg    <= rp_next;
      count_reg <= count_next;
    end
  end

  // Bank write; banks are cleared on reset so outputs read zero afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_re_reg[0] <= '0;
      bank_re_reg[1] <= '0;
      bank_im_reg[0] <= '0;
      bank_im_reg[1] <= '0;
    end else if (accept) begin
      bank_re_reg[wp_reg] <= wr_re;
      bank_im_reg[wp_reg] <= wr_im;
    end
  end

endmodule

// File: tb/tb_fft_stage_pingpong_buffer.sv
// Directed bench for fft_stage_pingpong_buffer (WIDTH=16, NPTS=16).
module tb_fft_stage_pingpong_buffer;

  localparam int WIDTH = 16;
  localparam int NPTS  = 16;
  localparam int FW    = NPTS * WIDTH;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [FW-1:0] in_re;
  logic [FW-1:0] in_im;
  logic          bitrev_en;
  logic          scale_en;
  logic          out_valid;
  logic          out_ready;
  logic [FW-1:0] out_re;
  logic [FW-1:0] out_im;
  logic [1:0]    level;

  int checks = 0;
  int errors = 0;

  fft_stage_pingpong_buffer #(.WIDTH(WIDTH), .NPTS(NPTS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .bitrev_en (bitrev_en),
    .scale_en  (scale_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic signed [31:0] lane(input logic [FW-1:0] v, input int k);
    logic signed [WIDTH-1:0] s;
    s = v[k*WIDTH +: WIDTH];
    return 32'(s);
  endfunction

  function automatic logic [FW-1:0] ramp(input int base);
    logic [FW-1:0] v;
    v = '0;
    for (int k = 0; k < NPTS; k++) begin
      v[k*WIDTH +: WIDTH] = WIDTH'(base + k);
    end
    return v;
  endfunction

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [FW-1:0] sc_vec;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_re     = '0;
    in_im     = '0;
    bitrev_en = 1'b0;
    scale_en  = 1'b0;
    out_ready = 1'b0;
    #12;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_level", 32'(level), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_zero", 32'(|{out_re, out_im}), 0);
    step();
    rst_n = 1'b1;
    step();
    check("idle_level", 32'(level), 0);

    // Passthrough
    in_re = ramp(0); in_im = '0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    $display("passthrough: out_valid=%0d level=%0d", out_valid, level);
    check("pt_out_valid", 32'(out_valid), 1);
    check("pt_level", 32'(level), 1);
    check("pt_lane0", lane(out_re, 0), 0);
    check("pt_lane5", lane(out_re, 5), 5);
    check("pt_lane15", lane(out_re, 15), 15);
    check("pt_im_zero", 32'(|out_im), 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("pt_drain_level", 32'(level), 0);
    check("pt_drain_valid", 32'(out_valid), 0);

    // Bit reverse
    in_re = ramp(0); bitrev_en = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0; bitrev_en = 1'b0;
    $display("bitrev: lanes %0d %0d %0d %0d .. %0d", lane(out_re, 0), lane(out_re, 1),
             lane(out_re, 2), lane(out_re, 3), lane(out_re, 15));
    check("br_lane0", lane(out_re, 0), 0);
    check("br_lane1", lane(out_re, 1), 8);
    check("br_lane2", lane(out_re, 2), 4);
    check("br_lane3", lane(out_re, 3), 12);
    check("br_lane15", lane(out_re, 15), 15);
    check("br_lane6", lane(out_re, 6), 6);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Scaling
    sc_vec = '0;
    sc_vec[0*WIDTH +: WIDTH] = 16'sd32767;
    sc_vec[1*WIDTH +: WIDTH] = -16'sd32768;
    sc_vec[2*WIDTH +: WIDTH] = 16'sd3;
    sc_vec[3*WIDTH +: WIDTH] = -16'sd3;
    in_re = sc_vec; in_im = sc_vec; scale_en = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0; scale_en = 1'b0; in_im = '0;
    $display("scale: lanes %0d %0d %0d %0d", lane(out_re, 0), lane(out_re, 1),
             lane(out_re, 2), lane(out_re, 3));
    check("sc_lane0", lane(out_re, 0), 16384);
    check("sc_lane1", lane(out_re, 1), -16384);
    check("sc_lane2", lane(out_re, 2), 2);
    check("sc_lane3", lane(out_re, 3), -1);
    check("sc_lane4", lane(out_re, 4), 0);
    check("sc_im1", lane(out_im, 1), -16384);
    check("sc_im3", lane(out_im, 3), -1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Backpressure: A, B, C offered back to back
    in_valid = 1'b1; in_re = ramp(100);
    step();
    in_re = ramp(200);
    step();
    in_re = ramp(300);
    $display("backpressure: level=%0d in_ready=%0d head=%0d", level, in_ready, lane(out_re, 0));
    check("bp_in_ready_full", 32'(in_ready), 0);
    check("bp_level2", 32'(level), 2);
    check("bp_head_a", lane(out_re, 0), 100);
    step();
    check("bp_hold_level", 32'(level), 2);
    check("bp_hold_head", lane(out_re, 3), 103);
    check("bp_hold_valid", 32'(out_valid), 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    $display("backpressure pop: level=%0d head=%0d", level, lane(out_re, 0));
    check("bp_pop_level", 32'(level), 1);
    check("bp_head_b", lane(out_re, 0), 200);
    check("bp_ready_again", 32'(in_ready), 1);
    step();
    in_valid = 1'b0;
    check("bp_c_level", 32'(level), 2);
    check("bp_c_head_b", lane(out_re, 1), 201);
    out_ready = 1'b1;
    step();
    check("bp_head_c", lane(out_re, 0), 300);
    check("bp_c_only", 32'(level), 1);
    step();
    out_ready = 1'b0;
    check("bp_empty", 32'(level), 0);

    // Simultaneous push and pop at level 1
    in_valid = 1'b1; in_re = ramp(400);
    step();
    in_re = ramp(500); out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    $display("push+pop: level=%0d head=%0d", level, lane(out_re, 0));
    check("pp_level", 32'(level), 1);
    check("pp_valid", 32'(out_valid), 1);
    check("pp_head_b", lane(out_re, 0), 500);
    step();
    out_ready = 1'b0;
    check("pp_empty", 32'(level), 0);

    // Reset mid-operation with two frames held
    in_valid = 1'b1; in_re = ramp(600);
    step();
    in_re = ramp(650);
    step();
    in_valid = 1'b0;
    check("mr_full", 32'(level), 2);
    rst_n = 1'b0;
    #2;
    $display("mid reset: out_valid=%0d level=%0d", out_valid, level);
    check("mr_out_valid", 32'(out_valid), 0);
    check("mr_level", 32'(level), 0);
    check("mr_out_zero", 32'(|{out_re, out_im}), 0);
    check("mr_in_ready", 32'(in_ready), 1);
    #2;
    rst_n = 1'b1;
    step();
    check("mr_after_level", 32'(level), 0);
    in_valid = 1'b1; in_re = ramp(700);
    step();
    in_valid = 1'b0;
    $display("post reset: out_valid=%0d head=%0d", out_valid, lane(out_re, 0));
    check("mr_new_valid", 32'(out_valid), 1);
    check("mr_new_head", lane(out_re, 0), 700);
    check("mr_new_level", 32'(level), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
